// File: rtl/alu_control_sequencer_if.sv
// Control-sequencer bus: instruction/flag inputs and the control word it drives.
interface alu_control_sequencer_if;
  logic       STEP_EN;
  logic [3:0] OPCODE;
  logic       CF;
  logic       ZF;
  logic       CO, MI, RO, RI, II, IO, AI, AO, BI, OI, CE, J;
  logic       SU;
  logic       EO_n;
  logic       FI_n;
  logic       HALTED;
  logic [2:0] STEP;

  // Driver side: IR/ALU/front panel feeding the sequencer.
  modport master (
    output STEP_EN, OPCODE, CF, ZF,
    input  CO, MI, RO, RI, II, IO, AI, AO, BI, OI, CE, J,
    input  SU, EO_n, FI_n, HALTED, STEP
  );

  // Sequencer side.
  modport slave (
    input  STEP_EN, OPCODE, CF, ZF,
    output CO, MI, RO, RI, II, IO, AI, AO, BI, OI, CE, J,
    output SU, EO_n, FI_n, HALTED, STEP
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// Microcoded control sequencer for the 8-bit CPU: steps T0..T4 per instruction
// and decodes the control word from {step, opcode, flags}.
module alu_control_sequencer #(
  parameter bit EARLY_END = 1'b1
) (
  input logic                    CLK,
  input logic                    CLR_n,
  alu_control_sequencer_if.slave bus
);

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
                         OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF;

  typedef struct packed {
    logic co, mi, ro, ri, ii, io, ai, ao, bi, oi, ce, j;
    logic su;
    logic eo_n;
    logic fi_n;
  } ctrl_t;

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;
  logic       run;
  logic       has_t3, has_t4;
  ctrl_t      ctl;

  // Sequencer only moves (and only drives controls) when enabled and not halted.
  assign run    = bus.STEP_EN && !halted_q;
  // Opcodes whose T3 / T4 microsteps are non-empty.
  assign has_t3 = (bus.OPCODE == OP_LDA) || (bus.OPCODE == OP_ADD) ||
                  (bus.OPCODE == OP_SUB) || (bus.OPCODE == OP_STA);
  assign has_t4 = (bus.OPCODE == OP_ADD) || (bus.OPCODE == OP_SUB);

  // Next step / halt decision.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (run) begin
      case (step_q)
        3'd0: step_d = 3'd1;
        3'd1: step_d = 3'd2;
        3'd2: begin
          if (bus.OPCODE == OP_HLT) halted_d = 1'b1;          // step parks at 2
          else if (!EARLY_END || has_t3) step_d = 3'd3;
          else step_d = 3'd0;
        end
        3'd3: step_d = (!EARLY_END || has_t4) ? 3'd4 : 3'd0;
        default: step_d = 3'd0;
      endcase
    end
  end

  // Step counter and halt latch; reset aborts any instruction in flight.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Control word decode; everything inactive in reset, stall or halt.
  always_comb begin
    ctl      = '0;
    ctl.eo_n = 1'b1;
    ctl.fi_n = 1'b1;
    if (CLR_n && run) begin
      case (step_q)
        3'd0: begin ctl.co = 1'b1; ctl.mi = 1'b1; end
        3'd1: begin ctl.ro = 1'b1; ctl.ii = 1'b1; ctl.ce = 1'b1; end
        3'd2: begin
          case (bus.OPCODE)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ctl.io = 1'b1; ctl.mi = 1'b1; end
            OP_LDI: begin ctl.io = 1'b1; ctl.ai = 1'b1; end
            OP_JMP: begin ctl.io = 1'b1; ctl.j = 1'b1; end
            // Flags only matter here, at T2.
            OP_JC:  if (bus.CF) begin ctl.io = 1'b1; ctl.j = 1'b1; end
            OP_JZ:  if (bus.ZF) begin ctl.io = 1'b1; ctl.j = 1'b1; end
            OP_OUT: begin ctl.ao = 1'b1; ctl.oi = 1'b1; end
            default: ;                                        // NOP, HLT, 9..D
          endcase
        end
        3'd3: begin
          case (bus.OPCODE)
            OP_LDA:         begin ctl.ro = 1'b1; ctl.ai = 1'b1; end
            OP_ADD, OP_SUB: begin ctl.ro = 1'b1; ctl.bi = 1'b1; end
            OP_STA:         begin ctl.ao = 1'b1; ctl.ri = 1'b1; end
            default: ;
          endcase
        end
        3'd4: begin
          // SU rides with FI_n so the latched flags describe the subtraction.
          if (has_t4) begin
            ctl.eo_n = 1'b0;
            ctl.ai   = 1'b1;
            ctl.fi_n = 1'b0;
            ctl.su   = (bus.OPCODE == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.CO     = ctl.co;
  assign bus.MI     = ctl.mi;
  assign bus.RO     = ctl.ro;
  assign bus.RI     = ctl.ri;
  assign bus.II     = ctl.ii;
  assign bus.IO     = ctl.io;
  assign bus.AI     = ctl.ai;
  assign bus.AO     = ctl.ao;
  assign bus.BI     = ctl.bi;
  assign bus.OI     = ctl.oi;
  assign bus.CE     = ctl.ce;
  assign bus.J      = ctl.j;
  assign bus.SU     = ctl.su;
  assign bus.EO_n   = ctl.eo_n;
  assign bus.FI_n   = ctl.fi_n;
  assign bus.HALTED = halted_q;
  assign bus.STEP   = step_q;

endmodule
